// File: rtl/pe_cluster_pkg.sv
// Shared constants and state encoding for the 8x8 PE cluster sequencer.
package pe_cluster_pkg;

    localparam int ROWS      = 8;
    localparam int DATA_W    = 16;
    localparam int SUM_W     = 36;
    localparam int K_MAX     = 16;
    localparam int DRAIN_CYC = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        WAIT,
        HOLD
    } state_t;

    // States in which the cluster accumulates or holds its sums.
    function automatic logic en_state(input state_t s);
        return (s == FEED) || (s == DRAIN) || (s == WAIT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/pe_cluster_sched_skew_line.sv
// skew_line: DEPTH-stage delay line for one lane plus its done tag.
// DEPTH 0 degenerates to a wire.
module skew_line #(
    parameter int DEPTH  = 0,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_done
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign out_data   = in_data;
        assign out_done   = in_done;
    end else begin : g_pipe
        logic [DATA_W-1:0] data_q [DEPTH];
        logic [DEPTH-1:0]  done_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < DEPTH; s++) begin
                    data_q[s] <= '0;
                end
                done_q <= '0;
            end else begin
                data_q[0] <= in_data;
                done_q[0] <= in_done;
                for (int s = 1; s < DEPTH; s++) begin
                    data_q[s] <= data_q[s-1];
                    done_q[s] <= done_q[s-1];
                end
            end
        end

        assign out_data = data_q[DEPTH-1];
        assign out_done = done_q[DEPTH-1];
    end

endmodule

// File: rtl/pe_cluster_sched.sv
// pe_cluster_sched: tile sequencer feeding a skewed wavefront into the 8x8 PE cluster.
// Optional WAIT watchdog enabled by defining PE_CLUSTER_SCHED_TIMEOUT_EN.
module pe_cluster_sched #(
    parameter int K_MAX       = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [4:0]                            cmd_k,
    output logic [3:0]                            act_rd_addr,
    input  logic [pe_cluster_pkg::ROWS*DATA_W-1:0] act_rd_data,
    output logic [3:0]                            wgt_rd_addr,
    input  logic [pe_cluster_pkg::ROWS*DATA_W-1:0] wgt_rd_data,
    output logic [pe_cluster_pkg::ROWS*DATA_W-1:0] cl_activations,
    output logic [pe_cluster_pkg::ROWS*DATA_W-1:0] cl_weights,
    output logic                                  cl_en,
    output logic [pe_cluster_pkg::ROWS-1:0]       cl_done,
    input  logic [pe_cluster_pkg::ROWS*pe_cluster_pkg::ROWS-1:0] cl_output_dones,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic                                  err,
    output logic                                  busy
);

    import pe_cluster_pkg::*;

    state_t     state;
    state_t     state_nx;
    logic [3:0] addr_q;
    logic [3:0] addr_nx;
    logic [4:0] k_q;
    logic [4:0] k_nx;
    logic [2:0] drain_q;
    logic [2:0] drain_nx;
    logic       err_nx;
    logic       feed_q;
    logic       last_q;
    logic       last_addr;
    logic       cmd_ok;
    logic       all_done;

    assign cmd_ok    = (cmd_k != 5'd0) && (cmd_k <= 5'(K_MAX));
    assign last_addr = ({1'b0, addr_q} == (k_q - 5'd1));
    assign all_done  = &cl_output_dones;

`ifdef PE_CLUSTER_SCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    logic [WCW-1:0] wcnt_q;
    logic [WCW-1:0] wcnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_nx;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = '0;
        k_nx     = k_q;
        drain_nx = '0;
        err_nx   = 1'b0;
`ifdef PE_CLUSTER_SCHED_TIMEOUT_EN
        wcnt_nx  = '0;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        k_nx     = cmd_k;
                        state_nx = CLEAR;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_nx = FEED;
            end
            FEED: begin
                if (last_addr) begin
                    state_nx = DRAIN;
                end else begin
                    addr_nx = addr_q + 4'd1;
                end
            end
            DRAIN: begin
                if (drain_q == 3'(DRAIN_CYC - 1)) begin
                    state_nx = WAIT;
                end else begin
                    drain_nx = drain_q + 3'd1;
                end
            end
            WAIT: begin
                if (all_done) begin
                    state_nx = HOLD;
                end
`ifdef PE_CLUSTER_SCHED_TIMEOUT_EN
                else if (wcnt_q == WCW'(TIMEOUT_CYC - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            feed_q    <= 1'b0;
            last_q    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cl_en     <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            addr_q    <= addr_nx;
            k_q       <= k_nx;
            drain_q   <= drain_nx;
            feed_q    <= (state == FEED);
            last_q    <= (state == FEED) && last_addr;
            cmd_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            cl_en     <= en_state(state_nx);
            res_valid <= (state_nx == HOLD);
            err       <= err_nx;
        end
    end

    assign act_rd_addr = addr_q;
    assign wgt_rd_addr = addr_q;

    logic [ROWS-1:0] act_tag;
    logic [ROWS-1:0] wgt_tag;

    // Read data is only meaningful the cycle after a FEED address; zero it otherwise.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DATA_W-1:0] act_in;
        logic [DATA_W-1:0] wgt_in;

        assign act_in = feed_q ? act_rd_data[i*DATA_W +: DATA_W] : '0;
        assign wgt_in = feed_q ? wgt_rd_data[i*DATA_W +: DATA_W] : '0;

        skew_line #(
            .DEPTH  (i),
            .DATA_W (DATA_W)
        ) u_act (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (act_in),
            .in_done  (last_q),
            .out_data (cl_activations[i*DATA_W +: DATA_W]),
            .out_done (act_tag[i])
        );

        skew_line #(
            .DEPTH  (i),
            .DATA_W (DATA_W)
        ) u_wgt (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (wgt_in),
            .in_done  (last_q),
            .out_data (cl_weights[i*DATA_W +: DATA_W]),
            .out_done (wgt_tag[i])
        );
    end

    assign cl_done = act_tag & wgt_tag;

endmodule
